// File: rtl/systolic_feeder.sv
// Job sequencer for a 2x2 broadcast systolic MAC array: latches one A/B operand pair,
// clears the array, streams the two inner-product steps and returns the packed C matrix.
module systolic_feeder #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] in_a,
    input  logic [4*DW-1:0] in_b,
    output logic            arr_rst,
    output logic [DW-1:0]   arr_a1,
    output logic [DW-1:0]   arr_a2,
    output logic [DW-1:0]   arr_b1,
    output logic [DW-1:0]   arr_b2,
    input  logic [CW-1:0]   arr_c11,
    input  logic [CW-1:0]   arr_c12,
    input  logic [CW-1:0]   arr_c21,
    input  logic [CW-1:0]   arr_c22,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*CW-1:0] out_c,
    output logic            busy,
    output logic [15:0]     job_count
);

    localparam int unsigned OPW = 4 * DW;
    localparam int unsigned RSW = 4 * CW;
    localparam int unsigned JCW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED0,
        S_FEED1,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic [RSW-1:0]   out_c_q, out_c_d;
    logic [JCW-1:0]   job_count_q, job_count_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE never accepts, so a new job waits for the following IDLE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_CLEAR;
            S_CLEAR: state_d = S_FEED0;
            S_FEED0: state_d = S_FEED1;
            S_FEED1: state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand, result and job-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            out_c_q     <= '0;
            job_count_q <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            out_c_q     <= out_c_d;
            job_count_q <= job_count_d;
        end
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        out_c_d     = out_c_q;
        job_count_d = job_count_q;
        if (state_q == S_IDLE && in_valid) begin
            a_d = in_a;
            b_d = in_b;
        end
        if (state_q == S_DRAIN) begin
            out_c_d = {arr_c22, arr_c21, arr_c12, arr_c11};
        end
        if (state_q == S_DONE && out_ready) begin
            job_count_d = job_count_q + JCW'(1);
        end
    end

    // Output decode from state and operand registers only
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        arr_rst   = rst | (state_q == S_CLEAR);
        arr_a1    = '0;
        arr_a2    = '0;
        arr_b1    = '0;
        arr_b2    = '0;
        case (state_q)
            S_FEED0: begin
                arr_a1 = a_q[0*DW +: DW];
                arr_a2 = a_q[2*DW +: DW];
                arr_b1 = b_q[0*DW +: DW];
                arr_b2 = b_q[1*DW +: DW];
            end
            S_FEED1: begin
                arr_a1 = a_q[1*DW +: DW];
                arr_a2 = a_q[3*DW +: DW];
                arr_b1 = b_q[2*DW +: DW];
                arr_b2 = b_q[3*DW +: DW];
            end
            default: ;
        endcase
    end

    assign out_c     = out_c_q;
    assign job_count = job_count_q;

endmodule
